// File: rtl/dot_pkg.sv
// Shared types and widths for the dot-product controller and its MAC datapath.
package dot_pkg;

    localparam int DW         = 12;
    localparam int AW         = 24;
    localparam int MAXLEN_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_core.sv
// Two-stage signed multiply-accumulate: stage 1 registers the accepted pair,
// stage 2 adds their full-width product into a wrapping accumulator.
module mac_core
    import dot_pkg::*;
#(
    parameter int DATA_W = DW,
    parameter int COEF_W = DW,
    parameter int ACC_W  = AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [DATA_W-1:0] a_p1_q, a_p1_d;
    logic signed [COEF_W-1:0] b_p1_q, b_p1_d;
    logic                     vld_p1_q, vld_p1_d;
    logic signed [ACC_W-1:0]  prod_p2;
    logic signed [ACC_W-1:0]  acc_p2_q, acc_p2_d;

    // Two's-complement add that simply drops the carry out (no saturation).
    function automatic logic signed [ACC_W-1:0] wrap_add(
        input logic signed [ACC_W-1:0] x,
        input logic signed [ACC_W-1:0] y
    );
        logic [ACC_W:0] s;
        s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        return $signed(s[ACC_W-1:0]);
    endfunction

    // Next-state for both stages; clr empties the pipe and zeroes the sum.
    always_comb begin
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        vld_p1_d = en;
        // stage 1 -> stage 2 boundary: operands sign-extended before multiply
        prod_p2  = ACC_W'(a_p1_q) * ACC_W'(b_p1_q);
        acc_p2_d = acc_p2_q;
        if (en) begin
            a_p1_d = a;
            b_p1_d = b;
        end
        if (vld_p1_q) begin
            acc_p2_d = wrap_add(acc_p2_q, prod_p2);
        end
        if (clr) begin
            vld_p1_d = 1'b0;
            acc_p2_d = '0;
        end
    end

    // Pipeline registers; reset clears data as well so outputs read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_p1_q   <= '0;
            b_p1_q   <= '0;
            vld_p1_q <= 1'b0;
            acc_p2_q <= '0;
        end else begin
            a_p1_q   <= a_p1_d;
            b_p1_q   <= b_p1_d;
            vld_p1_q <= vld_p1_d;
            acc_p2_q <= acc_p2_d;
        end
    end

    assign acc = acc_p2_q;

endmodule

// File: rtl/dot_ctrl.sv
// Dot-product controller: accepts len element pairs over a valid/ready
// handshake, lets the MAC pipe drain, then holds the result until taken.
module dot_ctrl
    import dot_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    localparam int LW    = $clog2(MAXLEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic signed [AW-1:0] f,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 busy
);

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [LW:0]     cnt_inc;
    logic [LW-1:0]   len_clamped;
    logic            accept;
    logic            clr;

    // Lengths above MAXLEN are treated as MAXLEN.
    always_comb begin
        len_clamped = len;
        if (32'(len) > MAXLEN) begin
            len_clamped = LW'(MAXLEN);
        end
    end

    // Next-state, counter and handshake outputs.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        cnt_inc   = {1'b0, cnt_q} + (LW+1)'(1);
        ready_in  = (state_q == LOAD);
        valid_out = (state_q == HOLD);
        busy      = (state_q != IDLE);
        accept    = valid_in && (state_q == LOAD);
        clr       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr   = 1'b1;
                    len_d = len_clamped;
                    cnt_d = '0;
                    state_d = (len_clamped == '0) ? HOLD : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_inc[LW-1:0];
                    if (cnt_inc == {1'b0, len_q}) begin
                        state_d = DRAIN;
                    end
                end
            end
            // Last product is still in flight through stage 2 here.
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (ready_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    mac_core #(
        .DATA_W (DW),
        .COEF_W (DW),
        .ACC_W  (AW)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (accept),
        .a     (a),
        .b     (b),
        .acc   (f)
    );

endmodule

// File: tb/tb_dot_ctrl.sv
// Directed bench for dot_ctrl with hand-computed expected results.
module tb_dot_ctrl;

    logic                clk;
    logic                reset;
    logic                start;
    logic [3:0]          len;
    logic signed [11:0]  a;
    logic signed [11:0]  b;
    logic                valid_in;
    logic                ready_in;
    logic signed [23:0]  f;
    logic                valid_out;
    logic                ready_out;
    logic                busy;

    int n_cmp = 0;
    int n_err = 0;

    dot_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .f         (f),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input logic [23:0] exp);
        chk(tag, {8'h0, f}, {8'h0, exp});
    endtask

    task automatic pair(input logic v, input logic signed [11:0] xa, input logic signed [11:0] xb);
        valid_in = v;
        a = xa;
        b = xb;
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = 4'd0; a = '0; b = '0;
        valid_in = 1'b0; ready_out = 1'b0;
        tick();
        tick();
        chkf("rst_f", 24'h0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ready_in", 32'(ready_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // len=3: (2,3) (-4,5) (7,-1) -> -21
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        chk("t1_ready_in", 32'(ready_in), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        pair(1'b1, 12'sd2, 12'sd3);
        pair(1'b1, -12'sd4, 12'sd5);
        pair(1'b1, 12'sd7, -12'sd1);
        valid_in = 1'b0;
        chk("t1_ready_drop", 32'(ready_in), 32'd0);
        chk("t1_vo_k1", 32'(valid_out), 32'd0);
        tick();
        chk("t1_vo_k2", 32'(valid_out), 32'd1);
        chkf("t1_f", -24'sd21);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        chk("t1_vo_drop", 32'(valid_out), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chkf("t1_f_kept", -24'sd21);

        // len=2 with the most negative operands -> wraps to 0x800000
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        pair(1'b1, -12'sd2048, -12'sd2048);
        pair(1'b1, -12'sd2048, -12'sd2048);
        valid_in = 1'b0;
        tick();
        chk("t2_vo", 32'(valid_out), 32'd1);
        chkf("t2_wrap", 24'h800000);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;

        // len=0 -> straight to HOLD with f=0
        start = 1'b1; len = 4'd0;
        tick();
        start = 1'b0;
        chk("t3_vo", 32'(valid_out), 32'd1);
        chk("t3_ready_in", 32'(ready_in), 32'd0);
        chkf("t3_f", 24'h0);
        tick();
        chk("t3_ready_in2", 32'(ready_in), 32'd0);
        chk("t3_vo_hold", 32'(valid_out), 32'd1);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        chk("t3_idle", 32'(busy), 32'd0);

        // valid_in in IDLE must be ignored
        pair(1'b1, 12'sd999, 12'sd999);
        valid_in = 1'b0;
        chk("t4_idle_vi", 32'(busy), 32'd0);

        // len=4 with stalls and a start pulse mid-LOAD -> 4180218
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        pair(1'b1, 12'sd5, 12'sd6);
        start = 1'b1; len = 4'd1;
        pair(1'b0, 12'sd111, 12'sd222);
        start = 1'b0;
        chk("t4_stall_ready", 32'(ready_in), 32'd1);
        pair(1'b0, -12'sd333, 12'sd44);
        pair(1'b1, -12'sd3, 12'sd7);
        pair(1'b0, 12'sd55, 12'sd66);
        pair(1'b0, 12'sd77, 12'sd88);
        chk("t4_still_load", 32'(ready_in), 32'd1);
        pair(1'b1, 12'sd100, -12'sd100);
        pair(1'b0, 12'sd1, 12'sd1);
        pair(1'b0, 12'sd2, 12'sd2);
        pair(1'b1, 12'sd2047, 12'sd2047);
        valid_in = 1'b0;
        chk("t4_drain", 32'(valid_out), 32'd0);
        tick();
        chkf("t4_f", 24'sd4180218);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            chk("t4_hold_vo", 32'(valid_out), 32'd1);
            chkf("t4_hold_f", 24'sd4180218);
        end
        start = 1'b1; ready_out = 1'b1; len = 4'd2;
        tick();
        start = 1'b0; ready_out = 1'b0;
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_no_restart_vo", 32'(valid_out), 32'd0);
        tick();
        chk("t4_no_restart", 32'(busy), 32'd0);
        chkf("t4_f_kept", 24'sd4180218);

        // reset mid-LOAD, then len=1 with (3,3) -> 9
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        pair(1'b1, 12'sd10, 12'sd10);
        pair(1'b1, 12'sd20, 12'sd20);
        valid_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chkf("t5_rst_f", 24'h0);
        chk("t5_rst_vo", 32'(valid_out), 32'd0);
        chk("t5_rst_ready", 32'(ready_in), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        pair(1'b1, 12'sd3, 12'sd3);
        valid_in = 1'b0;
        tick();
        chk("t5_vo", 32'(valid_out), 32'd1);
        chkf("t5_f", 24'sd9);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        chk("t5_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
